// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF/ID stage of the R/I/J CPU.
// Opcode encodings used by decode and the instruction word held while ID is empty.
package if_id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_inst_field_decode.sv
// Purely combinational split of a 32-bit instruction into R/I/J fields.
// Ports: inst_i in; opcode/rs/rt/rd/shamt/funct, imm_sext/imm_zext, class flags out.
module inst_field_decode
    import if_id_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst_i,
    output logic [5:0]        opcode_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic [DATA_W-1:0] imm_sext_o,
    output logic [DATA_W-1:0] imm_zext_o,
    output logic              is_rtype_o,
    output logic              is_jump_o,
    output logic              uses_rt_o
);

    assign opcode_o = inst_i[31:26];
    assign rs_o     = inst_i[25:21];
    assign rt_o     = inst_i[20:16];
    assign rd_o     = inst_i[15:11];
    assign shamt_o  = inst_i[10:6];
    assign funct_o  = inst_i[5:0];

    assign imm_sext_o = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
    assign imm_zext_o = {{(DATA_W-16){1'b0}}, inst_i[15:0]};

    assign is_rtype_o = (opcode_o == OP_RTYPE);
    assign is_jump_o  = (opcode_o == OP_J) | (opcode_o == OP_JAL);

    // rt is a source only for R-type, branches and stores;
    // for loads and ALU-immediates it is the destination.
    assign uses_rt_o = is_rtype_o
                     | (opcode_o == OP_BEQ)
                     | (opcode_o == OP_BNE)
                     | (opcode_o == OP_SW);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode front-end, load-use stall, J/JAL in ID.
// Ports: fetch word/PCs in, EX hazard/flush info in; stall, jump, decoded fields, stats out.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                CNT_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INST = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_inst,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_next_pc,
    input  logic              ex_flush,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    output logic              stall_o,
    output logic              jump_taken,
    output logic [DATA_W-1:0] jump_target,
    output logic              id_valid,
    output logic              id_issue,
    output logic [DATA_W-1:0] id_inst,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_next_pc,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_sext,
    output logic [DATA_W-1:0] imm_zext,
    output logic              is_rtype,
    output logic              is_jump,
    output logic              uses_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              id_valid_q, id_valid_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic [DATA_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_next_pc_q, id_next_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic hazard;

    inst_field_decode #(
        .DATA_W (DATA_W)
    ) u_dec (
        .inst_i     (id_inst_q[31:0]),
        .opcode_o   (opcode),
        .rs_o       (rs),
        .rt_o       (rt),
        .rd_o       (rd),
        .shamt_o    (shamt),
        .funct_o    (funct),
        .imm_sext_o (imm_sext),
        .imm_zext_o (imm_zext),
        .is_rtype_o (is_rtype),
        .is_jump_o  (is_jump),
        .uses_rt_o  (uses_rt)
    );

    // r0 is never a real load destination, so it cannot cause a hazard.
    assign hazard = id_valid_q & ex_valid & ex_mem_read
                  & (ex_rt != 5'd0)
                  & ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));

    assign stall_o    = hazard & ~ex_flush;
    assign id_issue   = id_valid_q & ~stall_o & ~ex_flush;
    assign jump_taken = id_valid_q & is_jump & ~ex_flush & ~stall_o;

    assign jump_target = {id_next_pc_q[DATA_W-1:28],
                          id_inst_q[25:0], 2'b00};

    assign id_valid   = id_valid_q;
    assign id_inst    = id_inst_q;
    assign id_pc      = id_pc_q;
    assign id_next_pc = id_next_pc_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_next_pc_d = id_next_pc_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (ex_flush) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end else if (stall_o) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end else if (jump_taken) begin
            // The word fetched alongside the jump is the fall-through
            // instruction; drop it while fetch redirects.
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end else begin
            id_valid_d   = 1'b1;
            id_inst_d    = if_inst;
            id_pc_d      = if_pc;
            id_next_pc_d = if_next_pc;
        end
    end

    // Negedge register: same edge on which fetch advances its PC.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= '0;
            id_next_pc_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_next_pc_q <= id_next_pc_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule
